// File: rtl/step_move_sequencer.sv
// step_move_sequencer: move scheduler for the step motor controller.
//
// Accepts a move command (step count, direction, step size, step period) and
// emits one-cycle step-enable pulses at the programmed period. Direction and
// step size are latched at start and held for the whole move.
//
// Optional feature: define STEP_RAMP_EN to compile in a linear accel/decel ramp
// (period starts at max(RAMP_START, cruise), steps down by RAMP_DEC to cruise,
// and mirrors back up over the final A steps). Undefined: constant cruise period.
//
// Ports:
//   clk                 system clock
//   resetb              asynchronous active-low reset
//   start               move request, sampled in IDLE
//   stop                abort request, sampled in RUN
//   target_steps        number of pulses for the move (0 = ignored)
//   step_period         cruise period in clk cycles (values < 2 clamp to 2)
//   dir_in, half_in     direction / half-step select, latched at start
//   step_en             one-cycle step pulse to the motion FSM indicator
//   rotation_direction  latched dir_in
//   step_size_sw        latched half_in
//   busy                move in progress
//   done                one-cycle pulse on normal completion
//   aborted             one-cycle pulse on stop
//   steps_left          pulses still to issue
module step_move_sequencer #(
    parameter int unsigned      CNT_W      = 16,
    parameter int unsigned      PER_W      = 20,
    parameter logic [PER_W-1:0] RAMP_START = PER_W'(200000),
    parameter logic [PER_W-1:0] RAMP_DEC   = PER_W'(2000)
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] target_steps,
    input  logic [PER_W-1:0] step_period,
    input  logic             dir_in,
    input  logic             half_in,
    output logic             step_en,
    output logic             rotation_direction,
    output logic             step_size_sw,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_left
);

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

    state_e           state_q, state_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [PER_W-1:0] per_q, per_d;      // period in use for the current step
    logic [CNT_W-1:0] steps_q, steps_d;
    logic             dir_q, dir_d;
    logic             half_q, half_d;
    logic             step_q, step_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;

    logic [PER_W-1:0] per_clamp;
    logic [PER_W-1:0] per_first;
    logic [PER_W-1:0] per_next;

    assign per_clamp = (step_period < PER_W'(2)) ? PER_W'(2) : step_period;

`ifdef STEP_RAMP_EN
    logic [PER_W-1:0] cruise_q, cruise_d;
    logic [CNT_W-1:0] accel_q, accel_d;  // number of accelerating steps so far
    logic [PER_W:0]   per_up;
    logic [PER_W-1:0] per_gap;
    logic [CNT_W-1:0] left_after;

    assign per_first  = (per_clamp > RAMP_START) ? per_clamp : RAMP_START;
    // One extra bit so the increment cannot wrap before saturation.
    assign per_up     = {1'b0, per_q} + {1'b0, RAMP_DEC};
    assign per_gap    = per_q - cruise_q;
    assign left_after = steps_q - CNT_W'(1);

    // Decelerate once the remaining steps fit inside the accel phase.
    always_comb begin
        per_next = per_q;
        accel_d  = accel_q;
        if (left_after <= accel_q) begin
            per_next = (per_up >= {1'b0, RAMP_START}) ? RAMP_START : per_up[PER_W-1:0];
        end else if (per_q > cruise_q) begin
            per_next = (per_gap > RAMP_DEC) ? (per_q - RAMP_DEC) : cruise_q;
            accel_d  = accel_q + CNT_W'(1);
        end
    end
`else
    logic unused_ramp;

    assign unused_ramp = ^{RAMP_START, RAMP_DEC};
    assign per_first   = per_clamp;
    assign per_next    = per_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        steps_d = steps_q;
        dir_d   = dir_q;
        half_d  = half_q;
        step_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
`ifdef STEP_RAMP_EN
        cruise_d = cruise_q;
`endif
        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (start && (target_steps != '0)) begin
                    steps_d  = target_steps;
                    dir_d    = dir_in;
                    half_d   = half_in;
                    per_d    = per_first;
                    cnt_d    = per_first - PER_W'(1);
                    busy_d   = 1'b1;
                    state_d  = StRun;
`ifdef STEP_RAMP_EN
                    cruise_d = per_clamp;
`endif
                end
            end
            StRun: begin
                if (stop) begin
                    // Stop wins over a coincident pulse; steps_left is frozen.
                    busy_d  = 1'b0;
                    abort_d = 1'b1;
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    step_d = 1'b1;
                    if (steps_q != '0) begin
                        steps_d = steps_q - CNT_W'(1);
                    end
                    if (steps_q <= CNT_W'(1)) begin
                        // busy stays high through FINISH and drops with done.
                        state_d = StFinish;
                    end else begin
                        per_d = per_next;
                        cnt_d = per_next - PER_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - PER_W'(1);
                end
            end
            StFinish: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            per_q   <= '0;
            steps_q <= '0;
            dir_q   <= 1'b0;
            half_q  <= 1'b0;
            step_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            steps_q <= steps_d;
            dir_q   <= dir_d;
            half_q  <= half_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

`ifdef STEP_RAMP_EN
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cruise_q <= '0;
            accel_q  <= '0;
        end else begin
            cruise_q <= cruise_d;
            if ((state_q == StIdle) && (state_d == StRun)) begin
                accel_q <= '0;
            end else if ((state_q == StRun) && !stop && (cnt_q == '0) &&
                         (steps_q > CNT_W'(1))) begin
                accel_q <= accel_d;
            end
        end
    end
`endif

    assign step_en            = step_q;
    assign rotation_direction = dir_q;
    assign step_size_sw       = half_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign aborted            = abort_q;
    assign steps_left         = steps_q;

endmodule

// File: tb/tb_step_move_sequencer.sv
// Self-checking bench for step_move_sequencer. A schedule-level model computes,
// per accepted move, the absolute cycle of every step pulse; outputs are then
// derived from that schedule and compared on every falling edge.
module tb_step_move_sequencer;

    localparam int CNT_W = 16;
    localparam int PER_W = 20;
    localparam int RS    = 50;
    localparam int RD    = 10;

    logic             clk = 1'b0;
    logic             resetb = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [CNT_W-1:0] target_steps = '0;
    logic [PER_W-1:0] step_period = '0;
    logic             dir_in = 1'b0;
    logic             half_in = 1'b0;
    logic             step_en, rotation_direction, step_size_sw;
    logic             busy, done, aborted;
    logic [CNT_W-1:0] steps_left;

    step_move_sequencer #(
        .CNT_W      (CNT_W),
        .PER_W      (PER_W),
        .RAMP_START (PER_W'(RS)),
        .RAMP_DEC   (PER_W'(RD))
    ) dut (
        .clk                (clk),
        .resetb             (resetb),
        .start              (start),
        .stop               (stop),
        .target_steps       (target_steps),
        .step_period        (step_period),
        .dir_in             (dir_in),
        .half_in            (half_in),
        .step_en            (step_en),
        .rotation_direction (rotation_direction),
        .step_size_sw       (step_size_sw),
        .busy               (busy),
        .done               (done),
        .aborted            (aborted),
        .steps_left         (steps_left)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;     // rising edges since reset release (model time base)

    // Model state: one move at a time, kept until the next accepted start.
    bit m_have = 0;
    bit m_ab   = 0;
    bit m_dir  = 0;
    bit m_half = 0;
    int m_n, m_l, m_abort_c, m_target, m_rdy;
    int m_pulses[$];
    int m_per[$];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            if (n_err < 40)
                $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        cmp(nm, act, exp);
    endtask

    // Pulse schedule for a move accepted at edge n.
    function automatic void plan(input int n, input int tgt, input int sp);
        int pc, cur, t;
`ifdef STEP_RAMP_EN
        int a, left;
        a = 0;
`endif
        pc  = (sp < 2) ? 2 : sp;
        cur = pc;
        t   = n;
`ifdef STEP_RAMP_EN
        if (RS > cur) cur = RS;
`endif
        m_per.delete();
        m_pulses.delete();
        for (int k = 1; k <= tgt; k++) begin
            t += cur;
            m_per.push_back(cur);
            m_pulses.push_back(t);
`ifdef STEP_RAMP_EN
            left = tgt - k;
            if (left <= a) begin
                cur = (cur + RD > RS) ? RS : cur + RD;
            end else if (cur > pc) begin
                cur = (cur - RD < pc) ? pc : cur - RD;
                a++;
            end
`endif
        end
    endfunction

    // Model update at each sampling edge.
    initial forever begin
        @(posedge clk or negedge resetb);
        if (!resetb) begin
            m_have   = 0;
            m_ab     = 0;
            m_dir    = 0;
            m_half   = 0;
            m_target = 0;
            m_rdy    = 0;
            m_pulses.delete();
        end else begin
            cyc++;
            if (m_have && !m_ab && stop && cyc > m_n && cyc <= m_l) begin
                m_ab      = 1;
                m_abort_c = cyc;
                m_rdy     = cyc + 1;
                while (m_pulses.size() > 0 && m_pulses[$] >= cyc) void'(m_pulses.pop_back());
            end
            if (start && target_steps != 0 && (!m_have || cyc >= m_rdy)) begin
                m_have   = 1;
                m_ab     = 0;
                m_n      = cyc;
                m_target = int'(target_steps);
                m_dir    = dir_in;
                m_half   = half_in;
                plan(cyc, int'(target_steps), int'(step_period));
                m_l      = m_pulses[$];
                m_rdy    = m_l + 2;
            end
        end
    end

    // Per-cycle comparison against the schedule.
    initial forever begin
        int cnt, e_end;
        bit se, e_busy, e_done, e_ab;
        @(negedge clk);
        cnt = 0; se = 0; e_busy = 0; e_done = 0; e_ab = 0;
        if (m_have) begin
            foreach (m_pulses[i]) begin
                if (m_pulses[i] <= cyc) cnt++;
                if (m_pulses[i] == cyc) se = 1;
            end
            e_end  = m_ab ? m_abort_c : m_l + 1;
            e_busy = (cyc < e_end);
            e_done = !m_ab && (cyc == m_l + 1);
            e_ab   = m_ab && (cyc == m_abort_c);
        end
        n_vec++;
        cmp("step_en", 32'(step_en), 32'(se));
        cmp("busy", 32'(busy), 32'(e_busy));
        cmp("done", 32'(done), 32'(e_done));
        cmp("aborted", 32'(aborted), 32'(e_ab));
        cmp("steps_left", 32'(steps_left), m_have ? 32'(m_target - cnt) : 32'd0);
        cmp("rotation_direction", 32'(rotation_direction), 32'(m_dir));
        cmp("step_size_sw", 32'(step_size_sw), 32'(m_half));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called at a falling edge; returns the edge at which start was sampled.
    task automatic do_start(input int tgt, input int per, input bit d, input bit h,
                            output int n);
        target_steps = CNT_W'(tgt);
        step_period  = PER_W'(per);
        dir_in       = d;
        half_in      = h;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n     = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        tick(3);
        lit("reset_busy", 32'(busy), 0);
        lit("reset_step_en", 32'(step_en), 0);
        lit("reset_steps_left", 32'(steps_left), 0);
        lit("reset_dir", 32'(rotation_direction), 0);
        resetb = 1'b1;
        tick(2);

        // 4 steps, period 10, dir=1; inputs change mid-move.
        do_start(4, 10, 1'b1, 1'b0, n);
`ifndef STEP_RAMP_EN
        lit("a_pulse_times", 32'(m_pulses[3]), 32'(n + 40));
        goto(n + 10);
        lit("a_step1", 32'(step_en), 1);
        lit("a_left1", 32'(steps_left), 3);
`endif
        goto(n + 15);
        dir_in = 1'b0; half_in = 1'b1; step_period = 3; target_steps = 99;
`ifndef STEP_RAMP_EN
        goto(n + 40);
        lit("a_step4", 32'(step_en), 1);
        lit("a_busy_last", 32'(busy), 1);
        goto(n + 41);
        lit("a_done", 32'(done), 1);
        lit("a_busy_done", 32'(busy), 0);
        lit("a_dir", 32'(rotation_direction), 1);
`endif
        goto(m_rdy + 2);

        // Period 0 clamps to 2.
        do_start(3, 0, 1'b0, 1'b1, n);
`ifndef STEP_RAMP_EN
        lit("b_model_p1", 32'(m_pulses[0]), 32'(n + 2));
        goto(n + 3);
        lit("b_gap", 32'(step_en), 0);
        goto(n + 6);
        lit("b_step3", 32'(step_en), 1);
        goto(n + 7);
        lit("b_done", 32'(done), 1);
`endif
        goto(m_rdy + 2);

        // Stop 35 cycles into an 8-step move.
        do_start(8, 10, 1'b0, 1'b0, n);
        goto(n + 34);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
`ifndef STEP_RAMP_EN
        lit("c_aborted", 32'(aborted), 1);
        lit("c_left", 32'(steps_left), 5);
        lit("c_busy", 32'(busy), 0);
`endif
        tick(30);

        // start held with zero target is ignored.
        target_steps = 0; step_period = 4; start = 1'b1;
        tick(10);
        lit("d_busy", 32'(busy), 0);
        lit("d_done", 32'(done), 0);
        start = 1'b0;
        tick(2);

        // Stop coincident with the final pulse; start during RUN ignored.
        do_start(2, 5, 1'b1, 1'b1, n);
        goto(n + 3);
        target_steps = 7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        goto(n + 9);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
`ifndef STEP_RAMP_EN
        lit("e_no_pulse", 32'(step_en), 0);
        lit("e_left", 32'(steps_left), 1);
`endif
        tick(20);

        // start held: 1-step moves restart exactly two cycles after the pulse.
        target_steps = 1; step_period = 2; start = 1'b1;
        @(negedge clk);
        n = cyc;
`ifndef STEP_RAMP_EN
        goto(n + 2);
        lit("f_step", 32'(step_en), 1);
        goto(n + 3);
        lit("f_done", 32'(done), 1);
        goto(n + 4);
        lit("f_restart", 32'(busy), 1);
`endif
        tick(8);
        start = 1'b0;
        goto(m_rdy + 2);

        // Asynchronous reset in the middle of a period.
        do_start(5, 10, 1'b0, 1'b1, n);
        goto(n + 15);
        #2 resetb = 1'b0;
        #1;
        lit("g_busy", 32'(busy), 0);
        lit("g_left", 32'(steps_left), 0);
        lit("g_half", 32'(step_size_sw), 0);
        tick(3);
        resetb = 1'b1;
        tick(30);
        do_start(2, 3, 1'b1, 1'b0, n);
`ifndef STEP_RAMP_EN
        goto(n + 3);
        lit("g_step1", 32'(step_en), 1);
        goto(n + 7);
        lit("g_done", 32'(done), 1);
`endif
        goto(m_rdy + 2);

`ifdef STEP_RAMP_EN
        begin
            int exp_sp[10] = '{50, 40, 30, 20, 20, 20, 20, 30, 40, 50};
            do_start(10, 20, 1'b0, 1'b0, n);
            for (int i = 0; i < 10; i++) lit("h_spacing", 32'(m_per[i]), 32'(exp_sp[i]));
            goto(m_rdy + 2);
        end
`endif

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/step_move_sequencer.md
# step_move_sequencer

Move scheduler for the step motor controller. It accepts a move command (step count, direction, step size, step period) and issues one-cycle step-enable pulses at the programmed rate into the motion state machine's `indicator` input. While a move is active it holds that state machine's `rotation_direction` and `step_size_sw` inputs stable. It reports busy, done and abort status to the front-panel or host logic.

## Interface
- `CNT_W`, 16: width of the step count and remaining-step counter.
- `PER_W`, 20: width of the step period, in clk cycles.
- `RAMP_START`, 20'd200000: initial and final step period when the ramp is compiled in.
- `RAMP_DEC`, 20'd2000: period change per step during acceleration and deceleration (ramp only).

Ports:
- `clk` in 1: system clock.
- `resetb` in 1: asynchronous, active-low reset.
- `start` in 1: move request; sampled only in IDLE.
- `stop` in 1: abort request; sampled in RUN.
- `target_steps` in CNT_W: number of step pulses for the move.
- `step_period` in PER_W: cruise period in cycles. Values below 2 are treated as 2.
- `dir_in` in 1: 0 = clockwise, 1 = counterclockwise.
- `half_in` in 1: 0 = full step, 1 = half step.
- `step_en` out 1: one-cycle step pulse, driven to the motion FSM `indicator`.
- `rotation_direction` out 1: latched `dir_in`.
- `step_size_sw` out 1: latched `half_in`.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse when a move completes normally.
- `aborted` out 1: one-cycle pulse when a move is ended by `stop`.
- `steps_left` out CNT_W: steps still to issue.

## Operation
- States are IDLE, RUN and FINISH. All outputs are registered.
- Reset, asynchronous: state IDLE; every output 0; period counter 0.
- IDLE, with `start`=1 and `target_steps`≠0:
  - latch `target_steps` into `steps_left`;
  - latch `dir_in` and `half_in` into the direction and step-size outputs;
  - latch the clamped period;
  - load the period counter with period−1;
  - go to RUN.
- IDLE, with `start`=1 and `target_steps`=0: ignored, no `done`.
- RUN: the period counter decrements each cycle. When it is 0:
  - `step_en`=1 for one cycle and `steps_left` decrements;
  - if `steps_left` was 1, go to FINISH;
  - otherwise reload the counter with the current period−1.
- FINISH: `done`=1 for one cycle, then IDLE.
- `stop` in RUN: go to IDLE at the next edge with `aborted`=1 for one cycle and no further `step_en`. `steps_left` keeps the value it had at abort.
- `stop` and a counter-zero event in the same cycle: `stop` wins and no pulse is issued.
- The direction and step-size outputs and the latched period never change during RUN. Changes on `dir_in`, `half_in`, `step_period` and `target_steps` take effect only on the next accepted start.
- `start` during RUN or FINISH is ignored, not queued.
- `steps_left` is never decremented below 0. Maximum move length is 2^CNT_W−1 steps.

## Timing
- Start is sampled at edge N. `busy`=1 from cycle N+1.
- The first `step_en` is asserted P cycles after edge N, where P is the effective period. Subsequent pulses are spaced exactly P cycles apart.
- The last `step_en` is at cycle L. Then `done`=1 and `busy`=0 at L+1, and IDLE at L+2. A new start is accepted from L+2.
- `stop` is sampled at edge S. Then `busy`=0 and `aborted`=1 at S+1.
- `step_en` is never high for two consecutive cycles, because the minimum period is 2.

## Configuration
- `STEP_RAMP_EN` defined:
  - the effective period starts at max(`RAMP_START`, P_cruise);
  - after each pulse, the period decreases by `RAMP_DEC`, saturating at P_cruise;
  - the sequencer counts the number of accelerating steps, A;
  - once `steps_left` ≤ A, the period increases by `RAMP_DEC` per step, saturating at `RAMP_START`;
  - arithmetic is PER_W bits with explicit saturation and no wrap.
- `STEP_RAMP_EN` undefined: every pulse uses P_cruise, and no ramp registers are synthesized.

## Test plan
- Reset during RUN, with `resetb` low mid-period: all outputs 0 immediately, no `step_en` after release, next start behaves normally.
- `target_steps`=4, `step_period`=10, `dir_in`=1, `half_in`=0: four `step_en` pulses at cycles +10, +20, +30, +40 after start; `done` at +41; `rotation_direction`=1 throughout.
- `step_period`=0 and `target_steps`=3: pulses 2 cycles apart, never back-to-back.
- `target_steps`=8, period 10, `stop` asserted 35 cycles after start: three pulses, then `aborted`=1, `steps_left`=5, `done` never asserted.
- `start` held with `target_steps`=0: `busy` stays 0 and `done` stays 0. Toggling `dir_in` mid-move does not change `rotation_direction`.
- With `STEP_RAMP_EN`, `RAMP_START`=50, `RAMP_DEC`=10, period 20, 10 steps: pulse spacings are 50, 40, 30, 20, 20, 20, 20, 30, 40, 50.
